spi_flash: RTL and testbench



---
 rtl/spi_flash_pkg.sv | 23 ++
 rtl/spi_flash_sync.sv | 44 ++++
 rtl/spi_flash.sv | 209 ++++++++++++++++++++
 tb/tb_spi_flash.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared constants and types for the spi_flash responder.
//   - Opcodes understood by the command decoder.
//   - Transfer state enumeration.
//   - Number of dummy sclk cycles inserted by FAST_READ.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_PD        = 8'hB9;
  localparam logic [7:0] CMD_RELEASE   = 8'hAB;

  localparam int unsigned DUMMY_CYCLES = 8;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    IGNORE
  } state_e;

endpackage

// File: rtl/spi_flash_sync.sv
// spi_flash_sync: brings the SPI pins into the system clock domain.
//   clock_i      system clock
//   reset_i      asynchronous active-high reset
//   csb_i        raw chip select (active low)
//   sclk_i       raw SPI clock
//   io0_i        raw MOSI
//   csb_o        synchronized chip select
//   io0_o        synchronized MOSI, aligned with the sclk edge pulses
//   sclk_rise_o  one-cycle pulse on a synchronized sclk rising edge
//   sclk_fall_o  one-cycle pulse on a synchronized sclk falling edge
module spi_flash_sync (
  input  logic clock_i,
  input  logic reset_i,
  input  logic csb_i,
  input  logic sclk_i,
  input  logic io0_i,
  output logic csb_o,
  output logic io0_o,
  output logic sclk_rise_o,
  output logic sclk_fall_o
);

  logic [1:0] csb_q;
  logic [1:0] io0_q;
  logic [2:0] sclk_q;  // two sync stages plus one history stage for edge detection

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      csb_q  <= 2'b11;  // deselected while in reset
      io0_q  <= 2'b00;
      sclk_q <= 3'b000;
    end else begin
      csb_q  <= {csb_q[0], csb_i};
      io0_q  <= {io0_q[0], io0_i};
      sclk_q <= {sclk_q[1:0], sclk_i};
    end
  end

  assign csb_o       = csb_q[1];
  assign io0_o       = io0_q[1];
  assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_o = ~sclk_q[1] & sclk_q[2];

endmodule

// File: rtl/spi_flash.sv
// spi_flash: single-IO (SPI mode 0) serial NOR flash responder, oversampled by the system clock.
//   clock   system clock, at least 4x sclk
//   reset   asynchronous active-high reset
//   csb     chip select, active low
//   sclk    SPI clock, idle low
//   io0     MOSI, sampled on sclk rise
//   io1     MISO, updated on sclk fall
//   io1_oe  high only while read data is being shifted out
// Commands: READ (0x03), POWER_DOWN (0xB9), RELEASE (0xAB); others are ignored.
// Optional: define SPI_FLASH_FASTREAD_EN to accept FAST_READ (0x0B) with 8 dummy clocks.
// FILENAME names the boot image; the byte array mem holds it and is never written by the design.
module spi_flash
  import spi_flash_pkg::*;
#(
  parameter string       FILENAME  = "firmware.hex",
  parameter int unsigned MEM_BYTES = 16384,
  parameter int unsigned ADDR_W    = 24
) (
  input  logic clock,
  input  logic reset,
  input  logic csb,
  input  logic sclk,
  input  logic io0,
  output logic io1,
  output logic io1_oe
);

  localparam int unsigned MemAw  = $clog2(MEM_BYTES);
  localparam int unsigned CntW   = $clog2(ADDR_W);
  // The final serial bit is taken straight from io0, so one fewer bit is stored. Address bits
  // above MemAw fall off the top, which implements the modulo on the effective address.
  localparam int unsigned ShiftW = MemAw - 1;

  localparam logic [CntW-1:0] LastCmdBit   = CntW'(7);
  localparam logic [CntW-1:0] LastAddrBit  = CntW'(ADDR_W - 1);
  localparam logic [CntW-1:0] LastDummyBit = CntW'(DUMMY_CYCLES - 1);

  logic [7:0] mem [MEM_BYTES];

  logic csb_s, io0_s, sclk_rise, sclk_fall;

  spi_flash_sync u_sync (
    .clock_i     (clock),
    .reset_i     (reset),
    .csb_i       (csb),
    .sclk_i      (sclk),
    .io0_i       (io0),
    .csb_o       (csb_s),
    .io0_o       (io0_s),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall)
  );

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ShiftW-1:0] shift_q, shift_d;
  logic [MemAw-1:0]  addr_q, addr_d;
  logic              io1_q, io1_d;
  logic              oe_q, oe_d;
  logic              pd_q, pd_d;
  // Power-mode change requested by a completed opcode, applied when csb rises.
  logic              pm_req_q, pm_req_d;
  logic              pm_val_q, pm_val_d;
  logic              fast_q, fast_d;

  logic [7:0] opcode;
  logic [7:0] rd_byte;

  assign opcode  = {shift_q[6:0], io0_s};
  assign rd_byte = mem[addr_q];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    addr_d   = addr_q;
    io1_d    = io1_q;
    oe_d     = oe_q;
    pd_d     = pd_q;
    pm_req_d = pm_req_q;
    pm_val_d = pm_val_q;
    fast_d   = fast_q;

    if (csb_s) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      io1_d   = 1'b0;
      if (pm_req_q) begin
        pd_d     = pm_val_q;
        pm_req_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = CMD;
          cnt_d   = '0;
        end

        CMD: begin
          if (sclk_rise) begin
            shift_d = {shift_q[ShiftW-2:0], io0_s};
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == LastCmdBit) begin
              cnt_d   = '0;
              state_d = IGNORE;
              if (pd_q) begin
                if (opcode == CMD_RELEASE) begin
                  pm_req_d = 1'b1;
                  pm_val_d = 1'b0;
                end
              end else begin
                case (opcode)
                  CMD_READ: begin
                    state_d = ADDR;
                    fast_d  = 1'b0;
                  end
`ifdef SPI_FLASH_FASTREAD_EN
                  CMD_FAST_READ: begin
                    state_d = ADDR;
                    fast_d  = 1'b1;
                  end
`endif
                  CMD_PD: begin
                    pm_req_d = 1'b1;
                    pm_val_d = 1'b1;
                  end
                  CMD_RELEASE: begin
                    pm_req_d = 1'b1;
                    pm_val_d = 1'b0;
                  end
                  default: ;
                endcase
              end
            end
          end
        end

        ADDR: begin
          if (sclk_rise) begin
            shift_d = {shift_q[ShiftW-2:0], io0_s};
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == LastAddrBit) begin
              cnt_d   = '0;
              addr_d  = {shift_q, io0_s};
              state_d = fast_q ? DUMMY : DATA;
            end
          end
        end

        DUMMY: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastDummyBit) begin
              cnt_d   = '0;
              state_d = DATA;
            end
          end
        end

        DATA: begin
          if (sclk_fall) begin
            oe_d  = 1'b1;
            io1_d = rd_byte[~cnt_q[2:0]];  // MSB first
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCmdBit) begin
              cnt_d  = '0;
              addr_d = addr_q + MemAw'(1);  // power-of-two size wraps naturally
            end
          end
        end

        IGNORE: ;

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      addr_q   <= '0;
      io1_q    <= 1'b0;
      oe_q     <= 1'b0;
      pd_q     <= 1'b0;
      pm_req_q <= 1'b0;
      pm_val_q <= 1'b0;
      fast_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      addr_q   <= addr_d;
      io1_q    <= io1_d;
      oe_q     <= oe_d;
      pd_q     <= pd_d;
      pm_req_q <= pm_req_d;
      pm_val_q <= pm_val_d;
      fast_q   <= fast_d;
    end
  end

  assign io1    = io1_q;
  assign io1_oe = oe_q;

endmodule

// File: tb/tb_spi_flash.sv
// tb_spi_flash: directed, table-driven bench for spi_flash.
// Memory is preloaded through the hierarchy: 0x6F,0x00,0x00,0x0B at 0, 0xA5 at 4, 0xC3 at 0x3FFF.
module tb_spi_flash;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic csb   = 1'b1;
  logic sclk  = 1'b0;
  logic io0   = 1'b0;
  logic io1;
  logic io1_oe;

  int n_tests = 0;
  int n_fail  = 0;

  spi_flash #(
    .FILENAME  (""),
    .MEM_BYTES (16384),
    .ADDR_W    (24)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .csb    (csb),
    .sclk   (sclk),
    .io0    (io0),
    .io1    (io1),
    .io1_oe (io1_oe)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [23:0] addr;
    bit          dummy;
    int          nbytes;
    logic [31:0] exp_data;
    bit          exp_oe;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One sclk period: drive MOSI, sample MISO just before the rising edge, then fall.
  task automatic spi_bit(input logic mosi, output logic miso, output logic oe);
    io0 = mosi;
    #40;
    miso = io1;
    oe   = io1_oe;
    sclk = 1'b1;
    #40;
    sclk = 1'b0;
  endtask

  task automatic end_xfer();
    #40;
    csb = 1'b1;
    #120;
  endtask

  task automatic send_cmd(input logic [7:0] op);
    logic miso, oe;
    csb = 1'b0;
    #80;
    for (int i = 7; i >= 0; i--) spi_bit(op[i], miso, oe);
    end_xfer();
  endtask

  task automatic do_read(input logic [7:0] op, input logic [23:0] addr, input bit dummy,
                         input int nbytes, output logic [31:0] data, output bit oe_all,
                         output bit oe_any, output bit oe_pre);
    logic miso, oe;
    data   = '0;
    oe_all = 1'b1;
    oe_any = 1'b0;
    oe_pre = 1'b0;
    csb = 1'b0;
    #80;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(op[i], miso, oe);
      oe_pre = oe_pre | oe;
    end
    for (int i = 23; i >= 0; i--) begin
      spi_bit(addr[i], miso, oe);
      oe_pre = oe_pre | oe;
    end
    if (dummy) begin
      for (int i = 0; i < 8; i++) begin
        spi_bit(1'b0, miso, oe);
        oe_pre = oe_pre | oe;
      end
    end
    for (int i = 0; i < nbytes * 8; i++) begin
      spi_bit(1'b0, miso, oe);
      data   = {data[30:0], miso};
      oe_all = oe_all & oe;
      oe_any = oe_any | oe;
    end
    end_xfer();
  endtask

  initial begin
    logic [31:0] data;
    bit          oe_all, oe_any, oe_pre;
    logic        miso, oe;

    for (int i = 0; i < 16384; i++) dut.mem[i] = 8'h00;
    dut.mem[0]       = 8'h6F;
    dut.mem[1]       = 8'h00;
    dut.mem[2]       = 8'h00;
    dut.mem[3]       = 8'h0B;
    dut.mem[4]       = 8'hA5;
    dut.mem[16383]   = 8'hC3;

    vecs[0] = '{"read_4B_at_0",    8'h03, 24'h000000, 1'b0, 4, 32'h6F00000B, 1'b1};
    vecs[1] = '{"read_wrap_3FFF",  8'h03, 24'h003FFF, 1'b0, 2, 32'h0000C36F, 1'b1};
    vecs[2] = '{"read_at_4",       8'h03, 24'h000004, 1'b0, 1, 32'h000000A5, 1'b1};
    vecs[3] = '{"read_2B_at_2",    8'h03, 24'h000002, 1'b0, 2, 32'h0000000B, 1'b1};
    vecs[4] = '{"read_addr_mod",   8'h03, 24'h010003, 1'b0, 1, 32'h0000000B, 1'b1};
`ifdef SPI_FLASH_FASTREAD_EN
    vecs[5] = '{"fast_read_at_0",  8'h0B, 24'h000000, 1'b1, 1, 32'h0000006F, 1'b1};
`else
    vecs[5] = '{"fast_read_off",   8'h0B, 24'h000000, 1'b1, 1, 32'h00000000, 1'b0};
`endif
    vecs[6] = '{"unknown_opcode",  8'h9F, 24'h000000, 1'b0, 1, 32'h00000000, 1'b0};

    // Reset state
    #33;
    check("reset_io1", {31'b0, io1}, 32'h0);
    check("reset_oe",  {31'b0, io1_oe}, 32'h0);
    reset = 1'b0;
    #100;
    check("post_reset_oe", {31'b0, io1_oe}, 32'h0);

    foreach (vecs[i]) begin
      do_read(vecs[i].op, vecs[i].addr, vecs[i].dummy, vecs[i].nbytes,
              data, oe_all, oe_any, oe_pre);
      check({vecs[i].name, "_data"}, data, vecs[i].exp_data);
      if (vecs[i].exp_oe)
        check({vecs[i].name, "_oe"}, {30'b0, oe_all, oe_pre}, 32'h2);
      else
        check({vecs[i].name, "_oe"}, {30'b0, oe_any, oe_pre}, 32'h0);
    end

    // Power-down blocks READ until RELEASE
    send_cmd(8'hB9);
    do_read(8'h03, 24'h000000, 1'b0, 1, data, oe_all, oe_any, oe_pre);
    check("pd_read_oe", {31'b0, oe_any}, 32'h0);
    check("pd_read_data", data, 32'h0);
    send_cmd(8'hAB);
    do_read(8'h03, 24'h000000, 1'b0, 1, data, oe_all, oe_any, oe_pre);
    check("release_read_data", data, 32'h6F);
    check("release_read_oe", {31'b0, oe_all}, 32'h1);

    // Abort after 12 address bits, then a clean READ at 4
    csb = 1'b0;
    #80;
    for (int i = 7; i >= 0; i--) spi_bit(8'h03 >> i, miso, oe);
    for (int i = 0; i < 12; i++) spi_bit(1'b1, miso, oe);
    end_xfer();
    do_read(8'h03, 24'h000004, 1'b0, 1, data, oe_all, oe_any, oe_pre);
    check("abort_then_read", data, 32'hA5);
    check("abort_then_read_oe", {30'b0, oe_all, oe_pre}, 32'h2);

    // Reset in the middle of a data byte
    csb = 1'b0;
    #80;
    for (int i = 7; i >= 0; i--) spi_bit(8'h03 >> i, miso, oe);
    for (int i = 0; i < 24; i++) spi_bit(1'b0, miso, oe);
    spi_bit(1'b0, miso, oe);
    spi_bit(1'b0, miso, oe);
    #40;
    check("mid_byte_io1", {31'b0, io1}, 32'h1);
    check("mid_byte_oe",  {31'b0, io1_oe}, 32'h1);
    reset = 1'b1;
    #1;
    check("async_reset_io1", {31'b0, io1}, 32'h0);
    check("async_reset_oe",  {31'b0, io1_oe}, 32'h0);
    #50;
    csb  = 1'b1;
    sclk = 1'b0;
    #50;
    reset = 1'b0;
    #100;
    do_read(8'h03, 24'h000000, 1'b0, 1, data, oe_all, oe_any, oe_pre);
    check("after_reset_read", data, 32'h6F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
